regfile_wb_arbiter: RTL

- Owns the register file's single write port (WriteSignal / WriteRegister / WriteData).
- Arbitrates between two writeback requesters, ALU and MEM (load path), using valid/ready handshakes.
- Keeps a per-register pending-write scoreboard so issue logic can stall on RAW hazards.
- Sits between the execute/memory stages and the register file, in the same clk domain.

---
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle: ALU/MEM requesters, issue port, register-file write port, scoreboard status.
// master = requester/issue side, slave = arbiter side.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_reg;
    logic [NREG-1:0]   busy_mask;
    logic              WriteSignal;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              err_overflow;
    logic              err_underflow;

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
               issue_valid, issue_reg,
        input  alu_ready, mem_ready, busy_mask, WriteSignal, WriteRegister,
               WriteData, err_overflow, err_underflow
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
               issue_valid, issue_reg,
        output alu_ready, mem_ready, busy_mask, WriteSignal, WriteRegister,
               WriteData, err_overflow, err_underflow
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin ALU/MEM writeback arbiter owning the register-file write port, plus per-register pending-write scoreboard.
// Latency: grant in cycle N drives the write port in N+1. Backpressure: loser sees ready=0 and must hold its request.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32,
    parameter int CNT_W  = 2
) (
    input logic                clk,
    input logic                reset,
    regfile_wb_arbiter_if.slave wb
);
    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] dat;
    } wr_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             ptr_mem;
    logic             alu_xfer;
    logic             mem_xfer;
    wr_t              grant_wr;
    logic [NREG-1:0]  inc_v;
    logic [NREG-1:0]  dec_v;
    logic [NREG-1:0]  busy;
    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic             ovf_hit;
    logic             unf_hit;

    assign wb.alu_ready = wb.alu_valid && (!wb.mem_valid || !ptr_mem);
    assign wb.mem_ready = wb.mem_valid && (!wb.alu_valid ||  ptr_mem);
    assign alu_xfer     = wb.alu_valid && wb.alu_ready;
    assign mem_xfer     = wb.mem_valid && wb.mem_ready;

    always_comb begin
        grant_wr = alu_xfer ? wr_t'{idx: wb.alu_reg, dat: wb.alu_data}
                            : wr_t'{idx: wb.mem_reg, dat: wb.mem_data};
    end

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_v[r] = wb.issue_valid && (wb.issue_reg == ADDR_W'(r));
            dec_v[r] = wb.WriteSignal && (wb.WriteRegister == ADDR_W'(r));
        end
    end

    // Retire at zero still lets a same-cycle issue land, so the count becomes 1.
    always_comb begin
        ovf_hit = 1'b0;
        unf_hit = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            if (dec_v[r] && cnt[r] == '0) begin
                unf_hit = 1'b1;
                if (inc_v[r])
                    cnt_nxt[r] = CNT_W'(1);
            end else if (inc_v[r] && !dec_v[r]) begin
                if (cnt[r] == CNT_MAX)
                    ovf_hit = 1'b1;
                else
                    cnt_nxt[r] = cnt[r] + CNT_W'(1);
            end else if (dec_v[r] && !inc_v[r]) begin
                cnt_nxt[r] = cnt[r] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++)
            busy[r] = (cnt[r] != '0);
    end

    assign wb.busy_mask = busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_mem          <= 1'b0;
            wb.WriteSignal   <= 1'b0;
            wb.WriteRegister <= '0;
            wb.WriteData     <= '0;
            wb.err_overflow  <= 1'b0;
            wb.err_underflow <= 1'b0;
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            if (alu_xfer || mem_xfer) begin
                ptr_mem          <= alu_xfer;
                // Register 0 completes the handshake but never reaches the file.
                wb.WriteSignal   <= (grant_wr.idx != '0);
                wb.WriteRegister <= grant_wr.idx;
                wb.WriteData     <= grant_wr.dat;
            end else begin
                wb.WriteSignal   <= 1'b0;
            end
            if (ovf_hit)
                wb.err_overflow  <= 1'b1;
            if (unf_hit)
                wb.err_underflow <= 1'b1;
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
        end
    end
endmodule
